// File: rtl/sha_mem_pkg.sv
// Shared types and constants for the SHA-256 memory responder.
package sha_mem_pkg;

  typedef logic [31:0] word_t;
  typedef logic [15:0] addr_t;

  localparam int HASH_WORDS = 8;

  typedef enum logic [2:0] {
    LOAD,
    KICK,
    WAIT_LO,
    WAIT_HI,
    RD0,
    DRAIN
  } state_t;

endpackage

// File: rtl/sha_mem_2r1w.sv
// Word storage with one write port and two registered read ports.
// Out-of-range accesses drop writes, read back as zero, and are flagged on port A.
module sha_mem_2r1w
  import sha_mem_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  we,
  input  addr_t waddr,
  input  word_t wdata,
  input  addr_t raddr_a,
  output word_t rdata_a,
  output logic  oor_a,
  input  logic  re_b,
  input  addr_t raddr_b,
  output word_t rdata_b
);

  localparam int    AW      = $clog2(DEPTH);
  localparam addr_t DEPTH_A = addr_t'(DEPTH);

  word_t mem [DEPTH];
  logic  w_ok, a_ok, b_ok;

  assign w_ok  = waddr < DEPTH_A;
  assign a_ok  = raddr_a < DEPTH_A;
  assign b_ok  = raddr_b < DEPTH_A;
  assign oor_a = !a_ok;

  // Array is deliberately not reset so its contents survive a reset.
  always_ff @(posedge clk) begin
    if (we && w_ok) mem[waddr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      rdata_a <= a_ok ? mem[raddr_a[AW-1:0]] : '0;
      if (re_b) rdata_b <= b_ok ? mem[raddr_b[AW-1:0]] : '0;
    end
  end

endmodule

// File: rtl/sha_mem_responder.sv
// Memory responder for the SHA-256 hasher plus host load/start/drain sequencer.
//   state   | meaning
//   LOAD    | accept host message words into MSG_ADDR..
//   KICK    | one-cycle start pulse to the hasher
//   WAIT_LO | wait for the hasher to drop its idle-high done
//   WAIT_HI | hasher running; wait for done to rise
//   RD0     | issue read of hash word OUT_ADDR+cnt
//   DRAIN   | present hash word to host until accepted
module sha_mem_responder
  import sha_mem_pkg::*;
#(
  parameter int    NUM_OF_WORDS = 20,
  parameter int    MEM_DEPTH    = 128,
  parameter addr_t MSG_ADDR     = 16'h0000,
  parameter addr_t OUT_ADDR     = 16'h0040
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        addr_err,
  output logic        start,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  input  logic        done,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data
);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wr_en, rd_b_en, oor_a;
  addr_t      wr_addr;
  word_t      wr_data, rd_b_data;

  assign message_addr = MSG_ADDR;
  assign output_addr  = OUT_ADDR;
  assign out_data     = rd_b_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= LOAD;
      cnt_q    <= '0;
      addr_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (oor_a) addr_err <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    start     = 1'b0;
    busy      = 1'b1;
    rd_b_en   = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = mem_addr;
    wr_data   = mem_write_data;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        wr_addr  = MSG_ADDR + addr_t'(cnt_q);
        wr_data  = in_data;
        if (in_valid) begin
          wr_en = 1'b1;
          if (cnt_q == 8'(NUM_OF_WORDS - 1)) begin
            cnt_d   = '0;
            state_d = KICK;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      KICK: begin
        start   = 1'b1;
        state_d = WAIT_LO;
      end
      WAIT_LO: begin
        wr_en = mem_we;
        if (!done) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        wr_en = mem_we;
        if (done) begin
          cnt_d   = '0;
          state_d = RD0;
        end
      end
      RD0: begin
        rd_b_en = 1'b1;
        state_d = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (cnt_q == 8'(HASH_WORDS - 1)) begin
            cnt_d   = '0;
            state_d = LOAD;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = RD0;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  sha_mem_2r1w #(.DEPTH(MEM_DEPTH)) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we      (wr_en),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .raddr_a (mem_addr),
    .rdata_a (mem_read_data),
    .oor_a   (oor_a),
    .re_b    (rd_b_en),
    .raddr_b (OUT_ADDR + addr_t'(cnt_q)),
    .rdata_b (rd_b_data)
  );

endmodule

// File: tb/tb_sha_mem_responder.sv
// Directed bench for sha_mem_responder with a hasher stub and hash-word scoreboard.
module tb_sha_mem_responder;
  import sha_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, out_valid, in_ready, out_ready;
  logic [31:0] in_data, out_data;
  logic        busy, addr_err, start, done, mem_we;
  logic [15:0] message_addr, output_addr, mem_addr;
  logic [31:0] mem_write_data, mem_read_data;

  int    tests = 0;
  int    fails = 0;
  int    start_cnt = 0;
  word_t exp_q [$];

  sha_mem_responder dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .busy           (busy),
    .addr_err       (addr_err),
    .start          (start),
    .message_addr   (message_addr),
    .output_addr    (output_addr),
    .done           (done),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (start) start_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Enter at a negedge; streams one job and checks the start pulse.
  task automatic load_job(input word_t base);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = base + 32'(i);
      chk("load_in_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("kick_start", {31'b0, start}, 32'd1);
    chk("kick_in_ready", {31'b0, in_ready}, 32'd0);
    chk("kick_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    chk("start_one_cycle", {31'b0, start}, 32'd0);
  endtask

  initial begin
    int w;
    int hold;
    word_t e;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    done = 1'b1; mem_we = 1'b0; mem_addr = '0; mem_write_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_addr_err", {31'b0, addr_err}, 32'd0);
    chk("rst_start", {31'b0, start}, 32'd0);
    chk("rst_mem_read_data", mem_read_data, 32'd0);
    chk("message_addr", {16'b0, message_addr}, 32'h0000);
    chk("output_addr", {16'b0, output_addr}, 32'h0040);
    reset = 1'b0;
    @(negedge clk);

    load_job(32'h01234567);
    chk("start_count_job1", start_cnt, 32'd1);

    mem_addr = 16'd5;
    @(negedge clk);
    chk("hasher_read_5", mem_read_data, 32'h0123456C);
    chk("wait_lo_busy", {31'b0, busy}, 32'd1);

    done = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 7; k++) begin
      mem_we = 1'b1; mem_addr = 16'(64 + k); mem_write_data = 32'hDEADBEEF + 32'(k);
      exp_q.push_back(32'hDEADBEEF + 32'(k));
      @(negedge clk);
    end
    mem_addr = 16'd71; mem_write_data = 32'h5555_5555;
    @(negedge clk);
    mem_write_data = 32'hDEADBEF6;
    exp_q.push_back(32'hDEADBEF6);
    @(negedge clk);
    chk("read_during_write_old", mem_read_data, 32'h5555_5555);
    mem_we = 1'b0;
    @(negedge clk);
    chk("readback_71", mem_read_data, 32'hDEADBEF6);
    chk("no_err_in_range", {31'b0, addr_err}, 32'd0);

    mem_addr = 16'd200;
    @(negedge clk);
    chk("oor_read_zero", mem_read_data, 32'd0);
    chk("oor_addr_err", {31'b0, addr_err}, 32'd1);
    mem_we = 1'b1; mem_addr = 16'd130; mem_write_data = 32'hBAD0BAD0;
    @(negedge clk);
    mem_we = 1'b0; mem_addr = 16'd2;
    @(negedge clk);
    chk("alias_mem2_unchanged", mem_read_data, 32'h01234569);
    chk("addr_err_sticky", {31'b0, addr_err}, 32'd1);
    mem_addr = 16'd0;

    done = 1'b1;
    w = 0;
    hold = 0;
    for (int cyc = 0; cyc < 100 && w < 8; cyc++) begin
      if (out_valid) begin
        if (w == 2 && hold < 3) begin
          out_ready = 1'b0;
          chk("stall_out_data", out_data, 32'hDEADBEF1);
          hold++;
        end else begin
          out_ready = 1'b1;
          e = exp_q.pop_front();
          chk("drain_word", out_data, e);
          w++;
        end
      end else begin
        out_ready = 1'b0;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("drain_count", w, 32'd8);
    chk("stall_cycles", hold, 32'd3);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("post_drain_busy", {31'b0, busy}, 32'd0);
    chk("post_drain_in_ready", {31'b0, in_ready}, 32'd1);
    chk("post_drain_out_valid", {31'b0, out_valid}, 32'd0);

    load_job(32'hA0000000);
    done = 1'b0;
    repeat (2) @(negedge clk);
    chk("wait_hi_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("async_rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done = 1'b1;
    @(negedge clk);
    chk("rel_start", {31'b0, start}, 32'd0);
    chk("rel_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rel_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rel_addr_err_clear", {31'b0, addr_err}, 32'd0);
    load_job(32'hC0DE0000);
    chk("start_count_total", start_cnt, 32'd3);
    mem_addr = 16'd19;
    @(negedge clk);
    chk("reload_word19", mem_read_data, 32'hC0DE0013);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
